// File: rtl/shift_pkg.sv
// Shared definitions for the shifter family: op encodings, FSM states and
// the power-of-two stage schedule used by the sequential shifter.
package shift_pkg;

    localparam int unsigned OP_W        = 2;
    localparam int unsigned NUM_STAGES  = 5;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned AMT_W       = 5;

    localparam logic [OP_W-1:0] OP_SLL = 2'b00;
    localparam logic [OP_W-1:0] OP_SRA = 2'b01;
    localparam logic [OP_W-1:0] OP_SRL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [AMT_W-1:0] STAGE_AMT [NUM_STAGES] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

    // Shift amount applied by stage idx; out-of-range indices shift by zero.
    function automatic logic [AMT_W-1:0] stage_amt(input logic [CNT_W-1:0] idx);
        if (32'(idx) < NUM_STAGES) begin
            return STAGE_AMT[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational single-stage shifter: shifts left, or right with a chosen
// fill bit, by amt_i positions.
module shift_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   amt_i,
    input  logic             right_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] fill_mask;

    assign fill_mask = ~({WIDTH{1'b1}} >> amt_i);

    always_comb begin
        if (right_i) begin
            data_o = (data_i >> amt_i) | (fill_i ? fill_mask : '0);
        end else begin
            data_o = data_i << amt_i;
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential barrel shifter: one shared stage applies 16/8/4/2/1 over five
// cycles. Define SHIFT_UNIT_SRL_EN to enable the logical right shift (op=10).
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(NUM_STAGES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             stage_en;
    logic [SHW-1:0]   stage_amt_s;
    logic             stage_right;
    logic             stage_fill;
    logic [WIDTH-1:0] stage_out;

    // Stage k inspects shamt bit (4-k) so the largest amount goes first.
    assign stage_en    = shamt_q[LAST_STAGE - cnt_q];
    assign stage_amt_s = stage_en ? SHW'(stage_amt(cnt_q)) : '0;

`ifdef SHIFT_UNIT_SRL_EN
    assign stage_right = (op_q == OP_SRA) || (op_q == OP_SRL);
    assign stage_fill  = (op_q == OP_SRA) && work_q[WIDTH-1];
`else
    assign stage_right = (op_q == OP_SRA);
    assign stage_fill  = work_q[WIDTH-1];
`endif

    shift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_stage (
        .data_i  (work_q),
        .amt_i   (stage_amt_s),
        .right_i (stage_right),
        .fill_i  (stage_fill),
        .data_o  (stage_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        op_d     = op_q;
        shamt_d  = shamt_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    work_d  = data_in;
                    op_d    = op;
                    shamt_d = shamt;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                work_d = stage_out;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == LAST_STAGE) begin
                    state_d  = ST_DONE;
                    result_d = stage_out;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            shamt_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            op_q     <= op_d;
            shamt_q  <= shamt_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, meaning datapath width; only 32 is supported.
REQ-002 The block SHALL expose parameter SHW, default 5, meaning shift-amount width, equal to log2(WIDTH).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request; accepted only in IDLE.
REQ-007 op  input  2  operation: 00 SLL, 01 SRA, 10 SRL (when the macro is enabled), 11 reserved.
REQ-008 data_in  input  WIDTH  operand to shift.
REQ-009 shamt  input  SHW  shift amount, 0..31.
REQ-010 result  output  WIDTH  shifted value; holds its value until the next accepted start.
REQ-011 busy  output  1  high while a request is in progress (SHIFT or DONE).
REQ-012 done  output  1  one-cycle pulse; result is valid while done is high.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
- IDLE -> SHIFT when start=1.
- SHIFT -> DONE after 5 stage cycles.
- DONE -> IDLE unconditionally.
REQ-014 On acceptance (edge N), the block SHALL latch data_in into the working register, and latch op and shamt.
REQ-015 At edges N+1..N+5 the block SHALL apply stages 16, 8, 4, 2, 1 in that order.
- Each stage shifts only if its shamt bit (4..0) is set; otherwise it passes the value through.
REQ-016 SLL SHALL zero-fill LSBs; SRA SHALL replicate bit 31 of the current working value into the MSBs.
REQ-017 Latency SHALL be fixed regardless of shamt: DONE is entered at edge N+5, done=1 for exactly that one cycle, and the FSM returns to IDLE at edge N+6.
REQ-018 shamt=0 SHALL produce result=data_in with the same latency.
REQ-019 start while busy (SHIFT or DONE) SHALL be ignored, with no effect on operands, state or result.
REQ-020 Changes on data_in, op or shamt after acceptance SHALL have no effect.
REQ-021 result SHALL update only when DONE is entered and SHALL be stable in IDLE.
REQ-022 op=11 SHALL behave as SLL.

Reset
REQ-023 Asserting reset_n low SHALL immediately force IDLE, result=0, busy=0, done=0, and clear the stage counter and working register.
REQ-024 Reset asserted mid-operation SHALL abort the request with no done pulse.
REQ-025 The first start SHALL be accepted at the first rising edge after reset_n deasserts.

Configuration
REQ-026 Macro SHIFT_UNIT_SRL_EN defined: op=10 SHALL perform a logical right shift (zero-fill MSBs) through the same 5-stage sequence.
REQ-027 Macro SHIFT_UNIT_SRL_EN undefined: op=10 SHALL behave as SLL, and the right-shift zero-fill path SHALL not be synthesized.

Structure
REQ-028 Package shift_pkg SHALL hold the following, shared with the single-cycle shifters:
- op encodings (OP_SLL, OP_SRA, OP_SRL);
- the FSM state enum;
- NUM_STAGES=5;
- the stage-amount table {16,8,4,2,1}.
REQ-029 Sub-module shift_stage SHALL be a combinational one-stage shifter by a power-of-two amount.
- It takes amount, direction and fill bit.
- The top SHALL instantiate it once and select the amount by the stage counter.

Verification
REQ-030 SLL: data_in=0x0000_0001, shamt=31, op=00 -> done at edge N+5, result=0x8000_0000, busy high for 6 cycles.
REQ-031 SRA: data_in=0x8000_0000, shamt=16, op=01 -> result=0xFFFF_8000; data_in=0x7000_0000, shamt=4 -> result=0x0700_0000.
REQ-032 shamt=0: data_in=0xDEAD_BEEF with op=00 and with op=01 -> result=0xDEAD_BEEF after the same 5-cycle latency.
REQ-033 Start at edge N+2 of a running request, carrying data_in=0x1234 -> ignored; the first result is correct, exactly one done pulse occurs, and result is unchanged afterwards.
REQ-034 reset_n low at edge N+3 -> busy=0, result=0 immediately, no done; a new request after release completes normally.
REQ-035 SRL: data_in=0x8000_0000, shamt=1, op=10 -> result=0x4000_0000 with SHIFT_UNIT_SRL_EN defined, and 0x0000_0000 (SLL) without it.
